// File: rtl/multicycle_control.sv
// Multi-cycle main control unit: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB
// states, with stall, memory-ready handshake and timeout, illegal-opcode and retire reporting.
module multicycle_control #(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter logic [5:0]  OP_RTYPE    = 6'b000000,
    parameter logic [5:0]  OP_ADDI     = 6'b001100,
    parameter logic [5:0]  OP_SUBI     = 6'b001101,
    parameter logic [5:0]  OP_SW       = 6'b010000,
    parameter logic [5:0]  OP_LW       = 6'b010001
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           OP,
    input  logic                 stall,
    input  logic                 mem_ready,
    output logic [1:0]           ALU_OP,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 ALU_src,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic                 mem2reg,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [2:0]           state,
    output logic                 instr_done,
    output logic                 illegal_op,
    output logic                 mem_error,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM_RD = 3'd3,
        MEM_WR = 3'd4,
        WB_ALU = 3'd5,
        WB_MEM = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        op_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;
    logic              abort_d;
    logic              illegal_d;

    function automatic logic known_op(input logic [5:0] o);
        return (o == OP_RTYPE) || (o == OP_ADDI) || (o == OP_SUBI) ||
               (o == OP_SW) || (o == OP_LW);
    endfunction

    // wait_cnt is 0 on the first cycle in a memory state, so the N-th cycle sees N-1
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign state       = state_q;

    always_comb begin
        state_d    = state_q;
        ALU_OP     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        ALU_src    = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        mem2reg    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        instr_done = 1'b0;
        abort_d    = 1'b0;
        illegal_d  = 1'b0;

        case (state_q)
            FETCH: begin
                if (!stall) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                if (known_op(OP)) begin
                    state_d = EXEC;
                end else begin
                    state_d   = FETCH;
                    illegal_d = 1'b1;
                end
            end
            EXEC: begin
                if (op_q == OP_RTYPE) begin
                    ALU_OP  = 2'b10;
                    state_d = WB_ALU;
                end else if (op_q == OP_ADDI) begin
                    ALU_src = 1'b1;
                    state_d = WB_ALU;
                end else if (op_q == OP_SUBI) begin
                    ALU_src = 1'b1;
                    ALU_OP  = 2'b01;
                    state_d = WB_ALU;
                end else if (op_q == OP_LW) begin
                    ALU_src = 1'b1;
                    state_d = MEM_RD;
                end else if (op_q == OP_SW) begin
                    ALU_src = 1'b1;
                    state_d = MEM_WR;
                end else begin
                    state_d = FETCH;
                end
            end
            MEM_RD: begin
                mem_read = 1'b1;
                ALU_src  = 1'b1;
                if (mem_ready) begin
                    state_d = WB_MEM;
                end else if (timeout_hit) begin
                    state_d = FETCH;
                    abort_d = 1'b1;
                end
            end
            MEM_WR: begin
                mem_write = 1'b1;
                ALU_src   = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end else if (timeout_hit) begin
                    state_d = FETCH;
                    abort_d = 1'b1;
                end
            end
            WB_ALU: begin
                reg_write  = 1'b1;
                reg_dst    = (op_q == OP_RTYPE);
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem2reg    = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Reset is asynchronous, so outputs must drop without waiting for an edge
        if (!rst_n) begin
            ALU_OP     = 2'b00;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            ALU_src    = 1'b0;
            mem_write  = 1'b0;
            mem_read   = 1'b0;
            mem2reg    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            instr_done = 1'b0;
            abort_d    = 1'b0;
            illegal_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            op_q       <= '0;
            wait_cnt   <= '0;
            retired    <= '0;
            illegal_op <= 1'b0;
            mem_error  <= 1'b0;
        end else begin
            state_q    <= state_d;
            illegal_op <= illegal_d;
            mem_error  <= abort_d;
            if (state_q == DECODE) begin
                op_q <= OP;
            end
            if ((state_q == MEM_RD) || (state_q == MEM_WR)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (instr_done) begin
                retired <= retired + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_multicycle_control;

    localparam logic [5:0] OPR    = 6'b000000;
    localparam logic [5:0] OPADDI = 6'b001100;
    localparam logic [5:0] OPSUBI = 6'b001101;
    localparam logic [5:0] OPSW   = 6'b010000;
    localparam logic [5:0] OPLW   = 6'b010001;
    localparam logic [5:0] OPBAD  = 6'b111111;

    // {reg_write, reg_dst, ALU_src, mem_write, mem_read, mem2reg, ir_write, pc_write, instr_done, illegal_op, mem_error}
    localparam logic [10:0] C_NONE = 11'h000;
    localparam logic [10:0] C_RW   = 11'h400;
    localparam logic [10:0] C_RD   = 11'h200;
    localparam logic [10:0] C_SRC  = 11'h100;
    localparam logic [10:0] C_MW   = 11'h080;
    localparam logic [10:0] C_MR   = 11'h040;
    localparam logic [10:0] C_M2R  = 11'h020;
    localparam logic [10:0] C_IR   = 11'h010;
    localparam logic [10:0] C_PC   = 11'h008;
    localparam logic [10:0] C_DONE = 11'h004;
    localparam logic [10:0] C_ILL  = 11'h002;
    localparam logic [10:0] C_MERR = 11'h001;

    typedef struct packed {
        logic [2:0]  st;
        logic [1:0]  alu;
        logic [10:0] ctl;
        logic [2:0]  ret;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] OP;
    logic       stall;
    logic       mem_ready;
    logic [1:0] ALU_OP;
    logic       reg_write, reg_dst, ALU_src, mem_write, mem_read, mem2reg;
    logic       ir_write, pc_write, instr_done, illegal_op, mem_error;
    logic [2:0] state;
    logic [2:0] retired;

    vec_t  exp_q[$];
    string nm_q[$];
    int    checks = 0;
    int    errors = 0;

    multicycle_control #(
        .CNT_WIDTH  (3),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .OP        (OP),
        .stall     (stall),
        .mem_ready (mem_ready),
        .ALU_OP    (ALU_OP),
        .reg_write (reg_write),
        .reg_dst   (reg_dst),
        .ALU_src   (ALU_src),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem2reg   (mem2reg),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .state     (state),
        .instr_done(instr_done),
        .illegal_op(illegal_op),
        .mem_error (mem_error),
        .retired   (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        vec_t        e;
        string       nm;
        logic [10:0] act_ctl;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            act_ctl = {reg_write, reg_dst, ALU_src, mem_write, mem_read, mem2reg,
                       ir_write, pc_write, instr_done, illegal_op, mem_error};
            checks++;
            if (state !== e.st || ALU_OP !== e.alu || act_ctl !== e.ctl || retired !== e.ret) begin
                errors++;
                $display("FAIL %s: got state=%0d alu=%b ctl=%b retired=%0d, want state=%0d alu=%b ctl=%b retired=%0d",
                         nm, state, ALU_OP, act_ctl, retired, e.st, e.alu, e.ctl, e.ret);
            end
        end
    end

    task automatic cyc(input string nm, input logic [5:0] op, input logic stl, input logic rdy,
                       input logic [2:0] st, input logic [1:0] alu, input logic [10:0] ctl,
                       input logic [2:0] ret);
        vec_t v;
        OP        = op;
        stall     = stl;
        mem_ready = rdy;
        v.st  = st;
        v.alu = alu;
        v.ctl = ctl;
        v.ret = ret;
        exp_q.push_back(v);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        OP        = '0;
        stall     = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset_hold", OPR, 1'b0, 1'b1, 3'd0, 2'b00, C_NONE, 3'd0);
        rst_n = 1'b1;

        // R-type
        cyc("r_fetch",  OPR, 1'b0, 1'b0, 3'd0, 2'b00, C_IR | C_PC, 3'd0);
        cyc("r_decode", OPR, 1'b0, 1'b0, 3'd1, 2'b00, C_NONE, 3'd0);
        cyc("r_exec",   OPR, 1'b0, 1'b0, 3'd2, 2'b10, C_NONE, 3'd0);
        cyc("r_wb",     OPR, 1'b0, 1'b0, 3'd5, 2'b00, C_RW | C_RD | C_DONE, 3'd0);

        // ADDI then SUBI back to back
        cyc("addi_fetch",  OPADDI, 1'b0, 1'b0, 3'd0, 2'b00, C_IR | C_PC, 3'd1);
        cyc("addi_decode", OPADDI, 1'b0, 1'b0, 3'd1, 2'b00, C_NONE, 3'd1);
        cyc("addi_exec",   OPADDI, 1'b0, 1'b0, 3'd2, 2'b00, C_SRC, 3'd1);
        cyc("addi_wb",     OPADDI, 1'b0, 1'b0, 3'd5, 2'b00, C_RW | C_DONE, 3'd1);
        cyc("subi_fetch",  OPSUBI, 1'b0, 1'b0, 3'd0, 2'b00, C_IR | C_PC, 3'd2);
        cyc("subi_decode", OPSUBI, 1'b0, 1'b0, 3'd1, 2'b00, C_NONE, 3'd2);
        cyc("subi_exec",   OPSUBI, 1'b0, 1'b0, 3'd2, 2'b01, C_SRC, 3'd2);
        cyc("subi_wb",     OPSUBI, 1'b0, 1'b0, 3'd5, 2'b00, C_RW | C_DONE, 3'd2);

        // LW, ready arrives on the 4th MEM_RD cycle, same cycle the timeout would fire
        cyc("lw_fetch",  OPLW, 1'b0, 1'b0, 3'd0, 2'b00, C_IR | C_PC, 3'd3);
        cyc("lw_decode", OPLW, 1'b0, 1'b0, 3'd1, 2'b00, C_NONE, 3'd3);
        cyc("lw_exec",   OPLW, 1'b0, 1'b0, 3'd2, 2'b00, C_SRC, 3'd3);
        cyc("lw_mem1",   OPLW, 1'b0, 1'b0, 3'd3, 2'b00, C_MR | C_SRC, 3'd3);
        cyc("lw_mem2",   OPLW, 1'b0, 1'b0, 3'd3, 2'b00, C_MR | C_SRC, 3'd3);
        cyc("lw_mem3",   OPLW, 1'b0, 1'b0, 3'd3, 2'b00, C_MR | C_SRC, 3'd3);
        cyc("lw_mem4",   OPLW, 1'b0, 1'b1, 3'd3, 2'b00, C_MR | C_SRC, 3'd3);
        cyc("lw_wb",     OPLW, 1'b0, 1'b0, 3'd6, 2'b00, C_RW | C_M2R | C_DONE, 3'd3);

        // SW, memory never ready: abort after 4 cycles
        cyc("sw_fetch",  OPSW, 1'b0, 1'b0, 3'd0, 2'b00, C_IR | C_PC, 3'd4);
        cyc("sw_decode", OPSW, 1'b0, 1'b0, 3'd1, 2'b00, C_NONE, 3'd4);
        cyc("sw_exec",   OPSW, 1'b0, 1'b0, 3'd2, 2'b00, C_SRC, 3'd4);
        cyc("sw_mem1",   OPSW, 1'b0, 1'b0, 3'd4, 2'b00, C_MW | C_SRC, 3'd4);
        cyc("sw_mem2",   OPSW, 1'b0, 1'b0, 3'd4, 2'b00, C_MW | C_SRC, 3'd4);
        cyc("sw_mem3",   OPSW, 1'b0, 1'b0, 3'd4, 2'b00, C_MW | C_SRC, 3'd4);
        cyc("sw_mem4",   OPSW, 1'b0, 1'b0, 3'd4, 2'b00, C_MW | C_SRC, 3'd4);
        cyc("sw_abort_fetch", OPBAD, 1'b0, 1'b0, 3'd0, 2'b00, C_IR | C_PC | C_MERR, 3'd4);

        // Illegal opcode
        cyc("bad_decode", OPBAD, 1'b0, 1'b0, 3'd1, 2'b00, C_NONE, 3'd4);
        cyc("bad_fetch",  OPSUBI, 1'b0, 1'b0, 3'd0, 2'b00, C_IR | C_PC | C_ILL, 3'd4);
        cyc("subi2_decode", OPSUBI, 1'b0, 1'b0, 3'd1, 2'b00, C_NONE, 3'd4);
        cyc("subi2_exec",   OPSUBI, 1'b0, 1'b0, 3'd2, 2'b01, C_SRC, 3'd4);
        cyc("subi2_wb",     OPSUBI, 1'b0, 1'b0, 3'd5, 2'b00, C_RW | C_DONE, 3'd4);

        // Stall holds FETCH
        cyc("stall1", OPR, 1'b1, 1'b0, 3'd0, 2'b00, C_NONE, 3'd5);
        cyc("stall2", OPR, 1'b1, 1'b0, 3'd0, 2'b00, C_NONE, 3'd5);
        cyc("stall3", OPR, 1'b1, 1'b0, 3'd0, 2'b00, C_NONE, 3'd5);
        cyc("r2_fetch",  OPR, 1'b0, 1'b0, 3'd0, 2'b00, C_IR | C_PC, 3'd5);
        cyc("r2_decode", OPR, 1'b0, 1'b0, 3'd1, 2'b00, C_NONE, 3'd5);
        cyc("r2_exec",   OPR, 1'b0, 1'b0, 3'd2, 2'b10, C_NONE, 3'd5);
        cyc("r2_wb",     OPR, 1'b0, 1'b0, 3'd5, 2'b00, C_RW | C_RD | C_DONE, 3'd5);

        // Two ADDIs take retired through 7 and wrap to 0
        for (int unsigned k = 0; k < 2; k++) begin
            cyc("addiw_fetch",  OPADDI, 1'b0, 1'b0, 3'd0, 2'b00, C_IR | C_PC, 3'(6 + k));
            cyc("addiw_decode", OPADDI, 1'b0, 1'b0, 3'd1, 2'b00, C_NONE, 3'(6 + k));
            cyc("addiw_exec",   OPADDI, 1'b0, 1'b0, 3'd2, 2'b00, C_SRC, 3'(6 + k));
            cyc("addiw_wb",     OPADDI, 1'b0, 1'b0, 3'd5, 2'b00, C_RW | C_DONE, 3'(6 + k));
        end
        cyc("r3_fetch",  OPR, 1'b0, 1'b0, 3'd0, 2'b00, C_IR | C_PC, 3'd0);
        cyc("r3_decode", OPR, 1'b0, 1'b0, 3'd1, 2'b00, C_NONE, 3'd0);
        cyc("r3_exec",   OPR, 1'b0, 1'b0, 3'd2, 2'b10, C_NONE, 3'd0);
        cyc("r3_wb",     OPR, 1'b0, 1'b0, 3'd5, 2'b00, C_RW | C_RD | C_DONE, 3'd0);

        // Reset in the middle of MEM_RD
        cyc("lw2_fetch",  OPLW, 1'b0, 1'b0, 3'd0, 2'b00, C_IR | C_PC, 3'd1);
        cyc("lw2_decode", OPLW, 1'b0, 1'b0, 3'd1, 2'b00, C_NONE, 3'd1);
        cyc("lw2_exec",   OPLW, 1'b0, 1'b0, 3'd2, 2'b00, C_SRC, 3'd1);
        cyc("lw2_mem1",   OPLW, 1'b0, 1'b0, 3'd3, 2'b00, C_MR | C_SRC, 3'd1);
        rst_n = 1'b0;
        cyc("rst_mid",    OPLW, 1'b0, 1'b0, 3'd0, 2'b00, C_NONE, 3'd0);
        rst_n = 1'b1;
        cyc("post_rst_fetch",  OPR, 1'b0, 1'b0, 3'd0, 2'b00, C_IR | C_PC, 3'd0);
        cyc("post_rst_decode", OPR, 1'b0, 1'b0, 3'd1, 2'b00, C_NONE, 3'd0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
